// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog: enable, divisor write port,
// divisor status and the divided clock with its edge strobes.
`default_nettype none

interface clock_divider_prog_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             div_wr;
    logic [CNT_W-1:0] div_in;
    logic             div_busy;
    logic [CNT_W-1:0] div_cur;
    logic             div_err;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;

    modport master (
        output en,
        output div_wr,
        output div_in,
        input  div_busy,
        input  div_cur,
        input  div_err,
        input  clk_out,
        input  rise_stb,
        input  fall_stb
    );

    modport slave (
        input  en,
        input  div_wr,
        input  div_in,
        output div_busy,
        output div_cur,
        output div_err,
        output clk_out,
        output rise_stb,
        output fall_stb
    );
endinterface

`default_nettype wire

// File: rtl/clock_divider_prog.sv
// ============================================================================
//  Module      : clock_divider_prog
//  Description : Runtime-programmable clock divider, glitch-free divisor
//                changes at period boundaries, enable gating, edge strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_prog #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 200
) (
    input  wire logic            clk_in,
    input  wire logic            rst_n,
    clock_divider_prog_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] C_MIN_DIV     = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_div_busy;
    logic             r_div_err;
    logic             r_clk_out;
    logic             r_rise_stb;
    logic             r_fall_stb;

    logic [CNT_W-1:0] w_low_len;
    logic [CNT_W-1:0] w_last;
    logic             w_wrap;
    logic             w_rise;
    logic             w_clamp;
    logic [CNT_W-1:0] w_wr_val;
    logic             w_apply;

    // Low phase is ceil(N/2) so odd divisors get the longer low half.
    assign w_low_len = r_div_cur - (r_div_cur >> 1);
    assign w_last    = r_div_cur - C_ONE;
    assign w_wrap    = bus.en && (r_cnt == w_last);
    assign w_rise    = bus.en && !w_wrap && (r_cnt == (w_low_len - C_ONE));

    assign w_clamp   = bus.div_wr && (bus.div_in < C_MIN_DIV);
    assign w_wr_val  = (bus.div_in < C_MIN_DIV) ? C_MIN_DIV : bus.div_in;

    // Pending divisor lands at a period boundary, or at once while stopped.
    assign w_apply   = r_div_busy && (w_wrap || !bus.en);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_clk_out  <= 1'b0;
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else if (!bus.en) begin
            r_cnt      <= '0;
            r_clk_out  <= 1'b0;
            r_rise_stb <= 1'b0;
            r_fall_stb <= r_clk_out;
        end else begin
            r_cnt      <= w_wrap ? '0 : (r_cnt + C_ONE);
            r_rise_stb <= w_rise;
            r_fall_stb <= w_wrap && r_clk_out;
            if (w_wrap) begin
                r_clk_out <= 1'b0;
            end else if (w_rise) begin
                r_clk_out <= 1'b1;
            end
        end
    end

    // A write coinciding with an apply becomes the next pending value.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cur  <= C_DEFAULT_DIV;
            r_div_pend <= C_DEFAULT_DIV;
            r_div_busy <= 1'b0;
            r_div_err  <= 1'b0;
        end else begin
            if (w_apply) begin
                r_div_cur <= r_div_pend;
            end
            if (bus.div_wr) begin
                r_div_pend <= w_wr_val;
                r_div_busy <= 1'b1;
            end else if (w_apply) begin
                r_div_busy <= 1'b0;
            end
            r_div_err <= r_div_err | w_clamp;
        end
    end

    assign bus.div_busy = r_div_busy;
    assign bus.div_cur  = r_div_cur;
    assign bus.div_err  = r_div_err;
    assign bus.clk_out  = r_clk_out;
    assign bus.rise_stb = r_rise_stb;
    assign bus.fall_stb = r_fall_stb;

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog with a per-cycle phase-position model.
`default_nettype none

module tb_clock_divider_prog;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    always #5 clk_in = ~clk_in;

    clock_divider_prog_if #(.CNT_W(16)) dut_if ();

    clock_divider_prog #(.CNT_W(16), .DEFAULT_DIV(200)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (dut_if.slave)
    );

    // Model: position inside the current period plus divisor bookkeeping.
    int m_pos, m_cur, m_pend;
    bit m_busy, m_err, m_clk, m_rise, m_fall;

    task automatic m_reset();
        m_pos = 0; m_cur = 200; m_pend = 200;
        m_busy = 0; m_err = 0; m_clk = 0; m_rise = 0; m_fall = 0;
    endtask

    task automatic m_step();
        bit old_clk;
        int n;
        old_clk = m_clk;
        n = m_cur;
        if (!dut_if.en) begin
            m_pos = 0; m_clk = 0; m_rise = 0; m_fall = old_clk;
            if (m_busy) begin m_cur = m_pend; m_busy = 0; end
        end else begin
            if (m_pos == n - 1) begin
                m_pos = 0;
                if (m_busy) begin m_cur = m_pend; m_busy = 0; end
            end else begin
                m_pos = m_pos + 1;
            end
            m_clk  = (m_pos >= (n + 1) / 2);
            m_rise = m_clk && !old_clk;
            m_fall = !m_clk && old_clk;
        end
        if (dut_if.div_wr) begin
            m_pend = (int'(dut_if.div_in) < 2) ? 2 : int'(dut_if.div_in);
            m_busy = 1;
            if (int'(dut_if.div_in) < 2) m_err = 1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_n)
                check("cycle_model",
                      {dut_if.clk_out, dut_if.rise_stb, dut_if.fall_stb,
                       dut_if.div_busy, dut_if.div_err, 11'd0, dut_if.div_cur},
                      {m_clk, m_rise, m_fall, m_busy, m_err, 11'd0, 16'(m_cur)});
        end
    end

    // Count clock edges until the selected strobe is seen (-1 on timeout).
    task automatic wait_stb(input bit rise, output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_in);
            n++;
            seen = rise ? dut_if.rise_stb : dut_if.fall_stb;
        end
        if (!seen) n = -1;
    endtask

    task automatic write_div(input int v);
        dut_if.div_wr = 1'b1;
        dut_if.div_in = 16'(v);
        @(negedge clk_in);
        dut_if.div_wr = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_clk"},  32'(dut_if.clk_out),  32'd0);
        check({name, "_stb"},  32'({dut_if.rise_stb, dut_if.fall_stb}), 32'd0);
        check({name, "_busy"}, 32'(dut_if.div_busy), 32'd0);
        check({name, "_err"},  32'(dut_if.div_err),  32'd0);
        check({name, "_cur"},  32'(dut_if.div_cur),  32'd200);
    endtask

    int n;

    initial begin
        dut_if.en = 1'b0; dut_if.div_wr = 1'b0; dut_if.div_in = '0;
        repeat (3) @(negedge clk_in);
        check_reset_vals("reset_init");
        rst_n = 1'b1;
        dut_if.en = 1'b1;

        // Default /200: 100 low, 100 high.
        wait_stb(1, n); check("def_first_rise", 32'(n), 32'd100);
        wait_stb(0, n); check("def_high",       32'(n), 32'd100);
        wait_stb(1, n); check("def_low",        32'(n), 32'd100);

        // Odd divisor written mid-period.
        wait_stb(0, n);
        repeat (50) @(negedge clk_in);
        write_div(5);
        check("odd_busy", 32'(dut_if.div_busy), 32'd1);
        check("odd_cur_old", 32'(dut_if.div_cur), 32'd200);
        wait_stb(0, n); check("odd_old_finish", 32'(n), 32'd149);
        check("odd_cur_new", 32'(dut_if.div_cur), 32'd5);
        wait_stb(1, n); check("odd_low",  32'(n), 32'd3);
        wait_stb(0, n); check("odd_high", 32'(n), 32'd2);
        wait_stb(1, n); check("odd_low2", 32'(n), 32'd3);

        // Wrap collision: N=4, pending 6, write 8 on the wrap cycle.
        write_div(4);
        wait_stb(0, n); check("n4_apply", 32'(n), 32'd1);
        write_div(6);
        @(negedge clk_in);
        @(negedge clk_in);
        write_div(8);
        check("coll_cur",  32'(dut_if.div_cur),  32'd6);
        check("coll_busy", 32'(dut_if.div_busy), 32'd1);
        check("coll_fall", 32'(dut_if.fall_stb), 32'd1);
        wait_stb(0, n); check("coll_period6", 32'(n), 32'd6);
        check("coll_cur8", 32'(dut_if.div_cur), 32'd8);

        // Enable drop while high, then pending applied while stopped.
        wait_stb(1, n); check("n8_rise", 32'(n), 32'd4);
        dut_if.en = 1'b0;
        @(negedge clk_in);
        check("en_drop", 32'({dut_if.clk_out, dut_if.fall_stb, dut_if.rise_stb}), 32'b010);
        write_div(10);
        check("en_off_busy", 32'(dut_if.div_busy), 32'd1);
        @(negedge clk_in);
        check("en_off_apply", 32'({dut_if.div_busy, 15'd0, dut_if.div_cur}), 32'd10);
        dut_if.en = 1'b1;
        wait_stb(1, n); check("en_restart_rise", 32'(n), 32'd5);

        // Clamp writes.
        write_div(1);
        check("clamp_err", 32'(dut_if.div_err), 32'd1);
        wait_stb(0, n); check("clamp_finish", 32'(n), 32'd4);
        check("clamp_cur", 32'(dut_if.div_cur), 32'd2);
        wait_stb(1, n); check("clamp_rise", 32'(n), 32'd1);
        wait_stb(0, n); check("clamp_fall", 32'(n), 32'd1);
        write_div(0);
        wait_stb(0, n); check("clamp0_fall", 32'(n), 32'd1);
        check("clamp0_state", 32'({dut_if.div_err, dut_if.div_busy, 14'd0, dut_if.div_cur}),
              32'h8000_0002);

        // Asynchronous reset mid-run.
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset_async");
        @(negedge clk_in);
        rst_n = 1'b1;
        wait_stb(1, n); check("post_reset_rise", 32'(n), 32'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
